// File: rtl/unidad_de_fetch_if.sv
// Bundle of the fetch unit's instruction-memory bus and its hand-off to ID.
// master: the fetch unit. slave: the memory, hazard unit and ID stage around it.
interface unidad_de_fetch_if #(
  parameter int ANCHO_PC = 10
);
  logic                stall;
  logic                salto;
  logic [ANCHO_PC-1:0] destino_salto;
  logic [31:0]         instruccion;
  logic [ANCHO_PC-1:0] direccion;
  logic [31:0]         instruccion_id;
  logic [ANCHO_PC-1:0] pc_id;
  logic                valido_id;
  logic                detenido;

  modport master (
    input  stall, salto, destino_salto, instruccion,
    output direccion, instruccion_id, pc_id, valido_id, detenido
  );

  modport slave (
    output stall, salto, destino_salto, instruccion,
    input  direccion, instruccion_id, pc_id, valido_id, detenido
  );
endinterface

// File: rtl/unidad_de_fetch.sv
// Instruction fetch stage driving a synchronous-read instruction memory.
// Handles stall, branch redirect with same-cycle squash, and HLT (all-zero word).
module unidad_de_fetch #(
  parameter int ANCHO_PC   = 10,
  parameter int DIR_INICIO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  unidad_de_fetch_if.master     bus
);
  localparam logic [ANCHO_PC-1:0] PC_INICIO = ANCHO_PC'(DIR_INICIO);
  localparam logic [31:0]         HLT       = 32'h0000_0000;

  typedef enum logic {RUN, HALT} estado_t;

  estado_t             estado_reg, estado_next;
  logic [ANCHO_PC-1:0] pc_reg, pc_next;
  logic [ANCHO_PC-1:0] pc_mem_reg, pc_mem_next;
  logic                valido_mem_reg, valido_mem_next;

  logic [ANCHO_PC-1:0] direccion;
  logic                valido_id;
  logic                halt_now;

  // pc_mem resets to 0 (not DIR_INICIO) so pc_id reads 1 while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_reg     <= RUN;
      pc_reg         <= PC_INICIO;
      pc_mem_reg     <= '0;
      valido_mem_reg <= 1'b0;
    end else begin
      estado_reg     <= estado_next;
      pc_reg         <= pc_next;
      pc_mem_reg     <= pc_mem_next;
      valido_mem_reg <= valido_mem_next;
    end
  end

  always_comb begin
    direccion       = pc_reg;
    valido_id       = 1'b0;
    halt_now        = 1'b0;
    estado_next     = estado_reg;
    pc_next         = pc_reg;
    pc_mem_next     = pc_mem_reg;
    valido_mem_next = valido_mem_reg;

    if (estado_reg == HALT)     direccion = pc_mem_reg;
    else if (bus.salto)         direccion = bus.destino_salto;
    else if (bus.stall)         direccion = pc_mem_reg;
    else                        direccion = pc_reg;

    valido_id = valido_mem_reg && !bus.salto && (estado_reg == RUN);
    halt_now  = valido_id && !bus.stall && (bus.instruccion == HLT);

    // The halting edge freezes fetch so direccion keeps pointing at the HLT word.
    if (estado_reg == RUN) begin
      if (halt_now) begin
        estado_next = HALT;
      end else if (bus.salto || !bus.stall) begin
        pc_mem_next     = direccion;
        pc_next         = direccion + 1'b1;
        valido_mem_next = 1'b1;
      end
    end
  end

  assign bus.direccion      = direccion;
  assign bus.instruccion_id = bus.instruccion;
  assign bus.pc_id          = pc_mem_reg + 1'b1;
  assign bus.valido_id      = valido_id;
  assign bus.detenido       = (estado_reg == HALT);
endmodule

// File: tb/tb_unidad_de_fetch.sv
// Directed bench for unidad_de_fetch: sequential run, stall, branch, HLT, wrap, async reset.
module tb_unidad_de_fetch;
  localparam logic [31:0] INS = 32'h0021_0820;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  logic [31:0] rom   [0:1023];
  logic [31:0] rom_w [0:1023];

  unidad_de_fetch_if #(.ANCHO_PC(10)) bus   ();
  unidad_de_fetch_if #(.ANCHO_PC(10)) bus_w ();

  unidad_de_fetch #(.ANCHO_PC(10), .DIR_INICIO(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  unidad_de_fetch #(.ANCHO_PC(10), .DIR_INICIO(1023)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  // Synchronous-read instruction memories.
  always @(posedge clk) bus.instruccion   <= rom[bus.direccion];
  always @(posedge clk) bus_w.instruccion <= rom_w[bus_w.direccion];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    bus.stall = 1'b0; bus.salto = 1'b0; bus.destino_salto = '0;
    reset = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    tests_run++; if (bus.direccion !== 10'd0) begin tests_failed++; $display("FAIL rst_dir got %0d want 0", bus.direccion); end
    tests_run++; if (bus.valido_id !== 1'b0) begin tests_failed++; $display("FAIL rst_valido got %b want 0", bus.valido_id); end
    tests_run++; if (bus.detenido !== 1'b0) begin tests_failed++; $display("FAIL rst_detenido got %b want 0", bus.detenido); end
    tests_run++; if (bus.pc_id !== 10'd1) begin tests_failed++; $display("FAIL rst_pc_id got %0d want 1", bus.pc_id); end
    tick();
    tests_run++; if (bus.direccion !== 10'd0 || bus.valido_id !== 1'b0) begin tests_failed++; $display("FAIL rst_held dir=%0d valido=%b want 0/0", bus.direccion, bus.valido_id); end
    release_reset();
    $display("[TB] test_reset done");
  endtask

  task automatic test_sequential();
    assert_reset();
    release_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++; if (bus.pc_id !== 10'(i) || bus.valido_id !== 1'b1 || bus.instruccion_id !== INS) begin tests_failed++; $display("FAIL seq_%0d pc_id=%0d valido=%b ins=%h want %0d/1/%h", i, bus.pc_id, bus.valido_id, bus.instruccion_id, i, INS); end
    end
    tick();
    tests_run++; if (bus.pc_id !== 10'd5 || bus.valido_id !== 1'b1 || bus.instruccion_id !== 32'h0 || bus.detenido !== 1'b0) begin tests_failed++; $display("FAIL seq_hlt pc_id=%0d valido=%b ins=%h det=%b want 5/1/0/0", bus.pc_id, bus.valido_id, bus.instruccion_id, bus.detenido); end
    tick();
    tests_run++; if (bus.detenido !== 1'b1 || bus.valido_id !== 1'b0 || bus.direccion !== 10'd4 || bus.pc_id !== 10'd5) begin tests_failed++; $display("FAIL seq_halted det=%b valido=%b dir=%0d pc_id=%0d want 1/0/4/5", bus.detenido, bus.valido_id, bus.direccion, bus.pc_id); end
    bus.salto = 1'b1; bus.stall = 1'b1; bus.destino_salto = 10'd0;
    #1;
    tests_run++; if (bus.direccion !== 10'd4 || bus.valido_id !== 1'b0) begin tests_failed++; $display("FAIL halt_ignores_salto dir=%0d valido=%b want 4/0", bus.direccion, bus.valido_id); end
    tick();
    bus.salto = 1'b0; bus.stall = 1'b0;
    tick();
    tests_run++; if (bus.detenido !== 1'b1 || bus.direccion !== 10'd4 || bus.pc_id !== 10'd5 || bus.valido_id !== 1'b0) begin tests_failed++; $display("FAIL halt_frozen det=%b dir=%0d pc_id=%0d valido=%b want 1/4/5/0", bus.detenido, bus.direccion, bus.pc_id, bus.valido_id); end
    $display("[TB] test_sequential done");
  endtask

  task automatic test_stall();
    assert_reset();
    release_reset();
    tick(); tick();
    bus.stall = 1'b1;
    #1;
    tests_run++; if (bus.direccion !== 10'd1) begin tests_failed++; $display("FAIL stall_dir got %0d want 1", bus.direccion); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++; if (bus.pc_id !== 10'd2 || bus.valido_id !== 1'b1 || bus.instruccion_id !== INS) begin tests_failed++; $display("FAIL stall_hold_%0d pc_id=%0d valido=%b ins=%h want 2/1/%h", i, bus.pc_id, bus.valido_id, bus.instruccion_id, INS); end
    end
    bus.stall = 1'b0;
    tick();
    tests_run++; if (bus.pc_id !== 10'd3 || bus.valido_id !== 1'b1) begin tests_failed++; $display("FAIL stall_resume pc_id=%0d valido=%b want 3/1", bus.pc_id, bus.valido_id); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_branch();
    assert_reset();
    release_reset();
    tick(); tick(); tick();
    bus.salto = 1'b1; bus.destino_salto = 10'd0;
    #1;
    tests_run++; if (bus.valido_id !== 1'b0 || bus.direccion !== 10'd0 || bus.pc_id !== 10'd3) begin tests_failed++; $display("FAIL branch_squash valido=%b dir=%0d pc_id=%0d want 0/0/3", bus.valido_id, bus.direccion, bus.pc_id); end
    tick();
    bus.salto = 1'b0;
    #1;
    tests_run++; if (bus.pc_id !== 10'd1 || bus.valido_id !== 1'b1 || bus.instruccion_id !== INS) begin tests_failed++; $display("FAIL branch_target pc_id=%0d valido=%b ins=%h want 1/1/%h", bus.pc_id, bus.valido_id, bus.instruccion_id, INS); end
    tick();
    tests_run++; if (bus.pc_id !== 10'd2) begin tests_failed++; $display("FAIL branch_next pc_id=%0d want 2", bus.pc_id); end
    $display("[TB] test_branch done");
  endtask

  task automatic test_salto_stall();
    assert_reset();
    release_reset();
    tick(); tick();
    bus.salto = 1'b1; bus.stall = 1'b1; bus.destino_salto = 10'd2;
    #1;
    tests_run++; if (bus.direccion !== 10'd2 || bus.valido_id !== 1'b0) begin tests_failed++; $display("FAIL both_dir dir=%0d valido=%b want 2/0", bus.direccion, bus.valido_id); end
    tick();
    bus.salto = 1'b0; bus.stall = 1'b0;
    #1;
    tests_run++; if (bus.pc_id !== 10'd3 || bus.valido_id !== 1'b1) begin tests_failed++; $display("FAIL both_target pc_id=%0d valido=%b want 3/1", bus.pc_id, bus.valido_id); end
    tick();
    tests_run++; if (bus.pc_id !== 10'd4 || bus.valido_id !== 1'b1) begin tests_failed++; $display("FAIL both_next pc_id=%0d valido=%b want 4/1", bus.pc_id, bus.valido_id); end
    $display("[TB] test_salto_stall done");
  endtask

  task automatic test_halt_stall();
    assert_reset();
    release_reset();
    repeat (5) tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++; if (bus.detenido !== 1'b0 || bus.pc_id !== 10'd5 || bus.valido_id !== 1'b1 || bus.instruccion_id !== 32'h0) begin tests_failed++; $display("FAIL hlt_stalled_%0d det=%b pc_id=%0d valido=%b ins=%h want 0/5/1/0", i, bus.detenido, bus.pc_id, bus.valido_id, bus.instruccion_id); end
    end
    bus.stall = 1'b0;
    tick();
    tests_run++; if (bus.detenido !== 1'b1 || bus.valido_id !== 1'b0 || bus.direccion !== 10'd4) begin tests_failed++; $display("FAIL hlt_after_stall det=%b valido=%b dir=%0d want 1/0/4", bus.detenido, bus.valido_id, bus.direccion); end
    $display("[TB] test_halt_stall done");
  endtask

  task automatic test_wrap();
    assert_reset();
    tests_run++; if (bus_w.direccion !== 10'd1023 || bus_w.pc_id !== 10'd1 || bus_w.valido_id !== 1'b0) begin tests_failed++; $display("FAIL wrap_rst dir=%0d pc_id=%0d valido=%b want 1023/1/0", bus_w.direccion, bus_w.pc_id, bus_w.valido_id); end
    release_reset();
    tick();
    tests_run++; if (bus_w.pc_id !== 10'd0 || bus_w.valido_id !== 1'b1 || bus_w.instruccion_id !== 32'hDEAD_BEEF || bus_w.direccion !== 10'd0) begin tests_failed++; $display("FAIL wrap_first pc_id=%0d valido=%b ins=%h dir=%0d want 0/1/deadbeef/0", bus_w.pc_id, bus_w.valido_id, bus_w.instruccion_id, bus_w.direccion); end
    tick();
    tests_run++; if (bus_w.pc_id !== 10'd1 || bus_w.instruccion_id !== 32'h1111_1111) begin tests_failed++; $display("FAIL wrap_second pc_id=%0d ins=%h want 1/11111111", bus_w.pc_id, bus_w.instruccion_id); end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_async_reset();
    assert_reset();
    release_reset();
    tick(); tick(); tick();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++; if (bus.direccion !== 10'd0 || bus.valido_id !== 1'b0 || bus.pc_id !== 10'd1 || bus.detenido !== 1'b0) begin tests_failed++; $display("FAIL async_run dir=%0d valido=%b pc_id=%0d det=%b want 0/0/1/0", bus.direccion, bus.valido_id, bus.pc_id, bus.detenido); end
    #1 reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests_run++; if (bus.pc_id !== 10'(i) || bus.valido_id !== 1'b1) begin tests_failed++; $display("FAIL async_seq_%0d pc_id=%0d valido=%b want %0d/1", i, bus.pc_id, bus.valido_id, i); end
    end
    tick();
    tests_run++; if (bus.detenido !== 1'b1) begin tests_failed++; $display("FAIL async_halt det=%b want 1", bus.detenido); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if (bus.detenido !== 1'b0 || bus.direccion !== 10'd0 || bus.valido_id !== 1'b0 || bus.pc_id !== 10'd1) begin tests_failed++; $display("FAIL async_halted det=%b dir=%0d valido=%b pc_id=%0d want 0/0/0/1", bus.detenido, bus.direccion, bus.valido_id, bus.pc_id); end
    #1 reset = 1'b1;
    tick();
    tests_run++; if (bus.pc_id !== 10'd1 || bus.valido_id !== 1'b1 || bus.instruccion_id !== INS) begin tests_failed++; $display("FAIL async_restart pc_id=%0d valido=%b ins=%h want 1/1/%h", bus.pc_id, bus.valido_id, bus.instruccion_id, INS); end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 1024; i++) begin
      rom[i]   = (i < 4) ? INS : 32'h0;
      rom_w[i] = (i < 4) ? 32'h1111_1111 : 32'h0;
    end
    rom_w[1023] = 32'hDEAD_BEEF;
    reset = 1'b1;
    bus.stall = 1'b0; bus.salto = 1'b0; bus.destino_salto = '0;
    bus_w.stall = 1'b0; bus_w.salto = 1'b0; bus_w.destino_salto = '0;
    #1;

    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_salto_stall();
    test_halt_stall();
    test_wrap();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
